// File: rtl/obc_bitserial_acc.sv
// Bit-serial offset-binary-coding accumulator: one bit-plane per cycle to an external ROM, shift-add into acc.
// Optional output saturation is compiled in with macro OBC_ACC_SAT_EN (default: 32-bit wrap).
module obc_bitserial_acc #(
  parameter int W    = 8,
  parameter int ACCW = 32 + W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*W-1:0] in_data,
  output logic [15:0]     bit_x,
  output logic            m,
  input  logic [31:0]     rom_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [16*W-1:0] sreg;
  logic [4:0]      b;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] term;
  logic [31:0]     result;
  logic            armed;
  logic            accept;
  logic            last_plane;

  assign last_plane = (b == 5'(W - 1));
  assign in_ready   = ((state == IDLE) && armed) ||
                      ((state == DONE) && out_valid && out_ready);
  assign accept     = in_valid && in_ready;
  assign m          = (state == SHIFT) && last_plane;
  assign term       = {{(ACCW - 32){rom_data[31]}}, rom_data} << b;

  // The whole sample vector shifts right each plane, so bit k*W always holds bit b of sample k.
  always_comb begin
    bit_x = '0;
    if (state == SHIFT) begin
      for (int unsigned k = 0; k < 16; k++) begin
        bit_x[k] = sreg[k*W];
      end
    end
  end

`ifdef OBC_ACC_SAT_EN
  always_comb begin
    if (!acc[ACCW-1] && (|acc[ACCW-2:31])) begin
      result = 32'h7FFF_FFFF;
    end else if (acc[ACCW-1] && !(&acc[ACCW-2:31])) begin
      result = 32'h8000_0000;
    end else begin
      result = acc[31:0];
    end
  end
`else
  assign result = 32'(acc);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      b         <= '0;
      acc       <= '0;
      armed     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
        end
        SHIFT: begin
          acc  <= acc + term;
          sreg <= sreg >> 1;
          b    <= b + 5'd1;
          if (last_plane) state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the (optionally clamped) result; then hold until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Accept overrides the DONE->IDLE move so back-to-back blocks skip the idle bubble.
      if (accept) begin
        sreg  <= in_data;
        acc   <= '0;
        b     <= '0;
        state <= SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_obc_bitserial_acc.sv
// Self-checking bench for obc_bitserial_acc; ROM stub computes a signed dot-product plane, model is the direct dot product.
module tb_obc_bitserial_acc;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [16*W-1:0] in_data = '0;
  logic            in_ready;
  logic [15:0]     bit_x;
  logic            m;
  logic [31:0]     rom_data;
  logic            out_valid;
  logic [31:0]     out_data;

  int          checks = 0;
  int          errors = 0;
  int          rom_mode = 0;
  logic [31:0] rom_const = '0;
  int          coef [16];
  logic [15:0] bx_hist [64];
  logic        m_hist [64];

  always #5 clk = ~clk;

  obc_bitserial_acc #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bit_x    (bit_x),
    .m        (m),
    .rom_data (rom_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // ROM stub: weighted sum of the plane bits, negated on the sign plane.
  always_comb begin
    longint s;
    s = 0;
    for (int k = 0; k < 16; k++) if (bit_x[k]) s += longint'(coef[k]);
    if (m) s = -s;
    rom_data = (rom_mode == 0) ? rom_const : s[31:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold(input longint e);
    logic [63:0] t;
    t = e;
`ifdef OBC_ACC_SAT_EN
    if (e > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (e < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return t[31:0];
  endfunction

  function automatic logic [31:0] expect_dot(input logic [16*W-1:0] d);
    longint e;
    logic signed [W-1:0] smp;
    e = 0;
    for (int k = 0; k < 16; k++) begin
      smp = d[k*W +: W];
      e += longint'(smp) * longint'(coef[k]);
    end
    return fold(e);
  endfunction

  function automatic logic [31:0] expect_const(input logic [31:0] c);
    return fold(longint'($signed(c)) * ((longint'(1) << W) - 1));
  endfunction

  function automatic logic [15:0] plane_of(input logic [16*W-1:0] d, input int p);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = d[k*W + p];
    return r;
  endfunction

  function automatic logic [16*W-1:0] rand_block();
    logic [16*W-1:0] d;
    for (int k = 0; k < 16; k++) d[k*W +: W] = W'($urandom());
    return d;
  endfunction

  task automatic start_block(input logic [16*W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = rand_block();
  endtask

  task automatic finish_block(output logic [31:0] res, output int lat);
    int i;
    i = 0;
    while (!out_valid && i < 40) begin
      bx_hist[i] = bit_x;
      m_hist[i]  = m;
      tick();
      i++;
    end
    lat = i;
    res = out_data;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    #1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [16*W-1:0] d, d2;
    logic [31:0]     res, exp1;
    logic [8:0]      mv;
    int              lat, ov;

    for (int k = 0; k < 16; k++) coef[k] = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_bit_x", bit_x, 0);
    chk("rst_m", m, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", in_ready, 0);
    tick();
    chk("ready_after_release", in_ready, 1);
    chk("idle_bit_x", bit_x, 0);

    // Constant ROM = 1
    rom_mode = 0;
    rom_const = 32'h1;
    start_block(rand_block());
    finish_block(res, lat);
    chk("lat_const1", lat, W + 1);
    chk("data_const1", res, 32'd255);
    handshake();

    // Constant ROM = -1, sign plane flag position
    rom_const = 32'hFFFF_FFFF;
    start_block(rand_block());
    finish_block(res, lat);
    chk("data_neg1", res, 32'hFFFF_FF01);
    for (int j = 0; j < 9; j++) mv[j] = m_hist[j];
    chk("m_plane_pattern", mv, 9'h080);
    handshake();

    // Sample k = k bit planes
    for (int k = 0; k < 16; k++) d[k*W +: W] = W'(k);
    rom_const = 32'h3;
    start_block(d);
    finish_block(res, lat);
    chk("plane0", bx_hist[0], 16'hAAAA);
    chk("plane1", bx_hist[1], 16'hCCCC);
    chk("data_const3", res, expect_const(32'h3));
    handshake();
    chk("idle_bit_x_after", bit_x, 0);

    // Overflow: wrap or saturate
    rom_const = 32'h7FFF_FFFF;
    start_block(rand_block());
    finish_block(res, lat);
`ifdef OBC_ACC_SAT_EN
    chk("data_ovf", res, 32'h7FFF_FFFF);
`else
    chk("data_ovf", res, 32'h7FFF_FF01);
`endif
    handshake();

    // Randomized blocks against the dot-product model
    rom_mode = 1;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 16; k++) coef[k] = int'($urandom_range(131071)) - 65536;
      d = rand_block();
      if (it == 0) for (int k = 0; k < 16; k++) d[k*W +: W] = {1'b1, {(W-1){1'b0}}};
      start_block(d);
      finish_block(res, lat);
      chk("rand_lat", lat, W + 1);
      chk("rand_plane3", bx_hist[3], plane_of(d, 3));
      chk("rand_data", res, expect_dot(d));
      handshake();
      for (int g = 0; g < int'($urandom_range(2)); g++) tick();
    end

    // Stall in DONE, then back-to-back accept on the release edge
    d = rand_block();
    d2 = rand_block();
    exp1 = expect_dot(d);
    start_block(d);
    finish_block(res, lat);
    chk("b2b_first", res, exp1);
    in_valid = 1'b1;
    in_data  = d2;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp1);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = rand_block();
    chk("b2b_valid_drop", out_valid, 0);
    chk("b2b_plane0", bit_x, plane_of(d2, 0));
    finish_block(res, lat);
    chk("b2b_lat", lat, W + 1);
    chk("b2b_second", res, expect_dot(d2));
    handshake();

    // Reset in the middle of SHIFT
    rom_mode = 0;
    rom_const = 32'h1;
    start_block(rand_block());
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_bit_x", bit_x, 0);
    chk("abort_m", m, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_ready_pre", in_ready, 0);
    tick();
    chk("abort_ready_post", in_ready, 1);
    ov = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) ov++;
      tick();
    end
    chk("abort_no_output", ov, 0);
    start_block(rand_block());
    finish_block(res, lat);
    chk("recover_lat", lat, W + 1);
    chk("recover_data", res, 32'd255);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
